de_scoreboard: RTL and testbench

Register-write scoreboard and issue controller for the decode stage. Keeps a per-architectural-register count of in-flight writes, from issue out of DE to retirement at WB. Produces the DE stall that sequences instructions into the DE latch, so DE no longer compares rd against AGEX/MEM/WB directly. Sits beside the register file in DE, fed by DE decode signals and the WB write-back bus.

---
 rtl/de_scoreboard.sv | 137 +++++++++++++
 tb/tb_de_scoreboard.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/de_scoreboard.sv
// de_scoreboard
//   Decode-stage register-write scoreboard and issue controller. Tracks the
//   number of in-flight writes per architectural register (issued out of DE,
//   retired at WB) and produces the DE stall/ack that sequences instructions
//   into the DE latch. Register x0 is never tracked.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   rs1_read_DE/rs1_DE    DE source 1 read enable / register ID
//   rs2_read_DE/rs2_DE    DE source 2 read enable / register ID
//   issue_req_DE          DE holds a valid instruction wanting to issue
//   wr_reg_DE/rd_DE       DE instruction writes a register / destination ID
//   wr_reg_WB/wregno_WB   WB retiring a register write / retiring ID
//   stall_DE              combinational: DE must hold and insert a bubble
//   issue_ack_DE          combinational: issue_req_DE & ~stall_DE
//   pending_mask          registered: bit r set while register r has writes in flight
//   inflight_total        registered: sum of all per-register counters
//   err_underflow         registered, sticky: retire seen for an idle register
module de_scoreboard #(
    parameter int REGWORDS  = 32,
    parameter int REGNOBITS = 5,
    parameter int CNTBITS   = 2,
    parameter int TOTBITS   = 7
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rs1_read_DE,
    input  logic [REGNOBITS-1:0] rs1_DE,
    input  logic                 rs2_read_DE,
    input  logic [REGNOBITS-1:0] rs2_DE,
    input  logic                 issue_req_DE,
    input  logic                 wr_reg_DE,
    input  logic [REGNOBITS-1:0] rd_DE,
    input  logic                 wr_reg_WB,
    input  logic [REGNOBITS-1:0] wregno_WB,
    output logic                 stall_DE,
    output logic                 issue_ack_DE,
    output logic [REGWORDS-1:0]  pending_mask,
    output logic [TOTBITS-1:0]   inflight_total,
    output logic                 err_underflow
);

    logic [CNTBITS-1:0] r_cnt     [REGWORDS];
    logic [CNTBITS-1:0] w_cnt_nxt [REGWORDS];
    logic [REGWORDS-1:0] r_pending;
    logic [REGWORDS-1:0] w_pending_nxt;
    logic [TOTBITS-1:0]  r_total;
    logic                r_err;

    logic               w_retire;
    logic               w_issue;
    logic               w_same_reg;
    logic [CNTBITS-1:0] w_cnt_rs1;
    logic [CNTBITS-1:0] w_cnt_rs2;
    logic [CNTBITS-1:0] w_cnt_rd;
    logic [CNTBITS-1:0] w_cnt_wb;
    logic               w_haz_rs1;
    logic               w_haz_rs2;
    logic               w_haz_sat;
    logic               w_stall;
    logic               w_tot_inc;
    logic               w_tot_dec;
    logic               w_underflow;

    assign w_cnt_rs1 = r_cnt[rs1_DE];
    assign w_cnt_rs2 = r_cnt[rs2_DE];
    assign w_cnt_rd  = r_cnt[rd_DE];
    assign w_cnt_wb  = r_cnt[wregno_WB];

    assign w_retire = wr_reg_WB & (wregno_WB != '0);

    // A source is busy while cnt - (same-cycle WB retire to it) > 0; the WB
    // bypass is legal because the register file writes on the negedge.
    assign w_haz_rs1 = rs1_read_DE & (rs1_DE != '0) & (w_cnt_rs1 != '0) &
                       ~(w_retire & (wregno_WB == rs1_DE) & (w_cnt_rs1 == CNTBITS'(1)));
    assign w_haz_rs2 = rs2_read_DE & (rs2_DE != '0) & (w_cnt_rs2 != '0) &
                       ~(w_retire & (wregno_WB == rs2_DE) & (w_cnt_rs2 == CNTBITS'(1)));
    assign w_haz_sat = wr_reg_DE & (rd_DE != '0) & (w_cnt_rd == '1);

    assign w_stall      = issue_req_DE & (w_haz_rs1 | w_haz_rs2 | w_haz_sat);
    assign stall_DE     = w_stall;
    assign issue_ack_DE = issue_req_DE & ~w_stall;

    assign w_issue    = issue_req_DE & ~w_stall & wr_reg_DE & (rd_DE != '0);
    assign w_same_reg = w_issue & w_retire & (rd_DE == wregno_WB);

    // Issue and retire to the same register cancel; a retire to an idle
    // register neither decrements nor touches the total.
    assign w_tot_inc   = w_issue & ~w_same_reg;
    assign w_tot_dec   = w_retire & ~w_same_reg & (w_cnt_wb != '0);
    assign w_underflow = w_retire & ~w_same_reg & (w_cnt_wb == '0);

    always_comb begin
        w_pending_nxt = '0;
        for (int unsigned r = 0; r < REGWORDS; r++) begin
            w_cnt_nxt[r] = r_cnt[r];
        end
        for (int unsigned r = 1; r < REGWORDS; r++) begin
            if (w_issue && !w_same_reg && rd_DE == REGNOBITS'(r)) begin
                w_cnt_nxt[r] = r_cnt[r] + CNTBITS'(1);
            end else if (w_tot_dec && wregno_WB == REGNOBITS'(r)) begin
                w_cnt_nxt[r] = r_cnt[r] - CNTBITS'(1);
            end
            w_pending_nxt[r] = (w_cnt_nxt[r] != '0);
        end
        w_cnt_nxt[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned r = 0; r < REGWORDS; r++) begin
                r_cnt[r] <= '0;
            end
            r_pending <= '0;
            r_total   <= '0;
            r_err     <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < REGWORDS; r++) begin
                r_cnt[r] <= w_cnt_nxt[r];
            end
            r_pending <= w_pending_nxt;
            if (w_tot_inc && !w_tot_dec) begin
                r_total <= r_total + TOTBITS'(1);
            end else if (w_tot_dec && !w_tot_inc) begin
                r_total <= r_total - TOTBITS'(1);
            end
            if (w_underflow) begin
                r_err <= 1'b1;
            end
        end
    end

    assign pending_mask   = r_pending;
    assign inflight_total = r_total;
    assign err_underflow  = r_err;

endmodule

// File: tb/tb_de_scoreboard.sv
module tb_de_scoreboard;

    logic        clk;
    logic        reset;
    logic        rs1_read_DE, rs2_read_DE;
    logic [4:0]  rs1_DE, rs2_DE;
    logic        issue_req_DE, wr_reg_DE;
    logic [4:0]  rd_DE;
    logic        wr_reg_WB;
    logic [4:0]  wregno_WB;
    logic        stall_DE, issue_ack_DE;
    logic [31:0] pending_mask;
    logic [6:0]  inflight_total;
    logic        err_underflow;

    int n_tests = 0;
    int n_fail  = 0;

    de_scoreboard #(
        .REGWORDS (32),
        .REGNOBITS(5),
        .CNTBITS  (2),
        .TOTBITS  (7)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rs1_read_DE   (rs1_read_DE),
        .rs1_DE        (rs1_DE),
        .rs2_read_DE   (rs2_read_DE),
        .rs2_DE        (rs2_DE),
        .issue_req_DE  (issue_req_DE),
        .wr_reg_DE     (wr_reg_DE),
        .rd_DE         (rd_DE),
        .wr_reg_WB     (wr_reg_WB),
        .wregno_WB     (wregno_WB),
        .stall_DE      (stall_DE),
        .issue_ack_DE  (issue_ack_DE),
        .pending_mask  (pending_mask),
        .inflight_total(inflight_total),
        .err_underflow (err_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          req;
        bit          wr;
        int          rd;
        bit          r1r;
        int          rs1;
        bit          r2r;
        int          rs2;
        bit          wbw;
        int          wbno;
        bit          e_stall;
        bit          e_ack;
        logic [31:0] e_mask;
        int          e_total;
        bit          e_err;
    } vec_t;

    // Reference model: plain integer write counts per register.
    int m_cnt[32];
    bit m_err;

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_err = 0;
    endfunction

    function automatic bit model_busy(int r, vec_t v);
        int eff;
        if (r == 0) return 0;
        eff = m_cnt[r] - ((v.wbw && v.wbno == r) ? 1 : 0);
        return eff > 0;
    endfunction

    function automatic bit model_stall(vec_t v);
        bit haz;
        haz = (v.r1r && model_busy(v.rs1, v)) || (v.r2r && model_busy(v.rs2, v)) ||
              (v.wr && v.rd != 0 && m_cnt[v.rd] == 3);
        return v.req && haz;
    endfunction

    function automatic void model_update(vec_t v);
        bit st;
        st = model_stall(v);
        if (v.req && !st && v.wr && v.rd != 0) m_cnt[v.rd]++;
        if (v.wbw && v.wbno != 0) begin
            if (m_cnt[v.wbno] > 0) m_cnt[v.wbno]--;
            else m_err = 1;
        end
    endfunction

    function automatic logic [31:0] model_mask();
        logic [31:0] m;
        m = '0;
        for (int i = 1; i < 32; i++) if (m_cnt[i] != 0) m[i] = 1'b1;
        return m;
    endfunction

    function automatic int model_total();
        int s;
        s = 0;
        for (int i = 0; i < 32; i++) s += m_cnt[i];
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        issue_req_DE = 0; wr_reg_DE = 0; rd_DE = '0;
        rs1_read_DE = 0; rs1_DE = '0; rs2_read_DE = 0; rs2_DE = '0;
        wr_reg_WB = 0; wregno_WB = '0;
    endtask

    // Called just after a negedge; returns just after the next negedge.
    task automatic do_reset();
        reset = 1;
        drive_idle();
        @(posedge clk);
        model_reset();
        #1;
        chk("reset_mask", pending_mask, 32'h0);
        chk("reset_total", 32'(inflight_total), 32'h0);
        chk("reset_err", 32'(err_underflow), 32'h0);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic apply(input string tag, input vec_t v, input bit use_model);
        bit          es, ea, ee;
        logic [31:0] em;
        int          et;
        issue_req_DE = v.req; wr_reg_DE = v.wr; rd_DE = 5'(v.rd);
        rs1_read_DE = v.r1r; rs1_DE = 5'(v.rs1);
        rs2_read_DE = v.r2r; rs2_DE = 5'(v.rs2);
        wr_reg_WB = v.wbw; wregno_WB = 5'(v.wbno);
        #1;
        if (use_model) begin
            es = model_stall(v);
            ea = v.req && !es;
        end else begin
            es = v.e_stall;
            ea = v.e_ack;
        end
        chk({tag, "_stall"}, 32'(stall_DE), 32'(es));
        chk({tag, "_ack"}, 32'(issue_ack_DE), 32'(ea));
        @(posedge clk);
        model_update(v);
        #1;
        if (use_model) begin
            em = model_mask(); et = model_total(); ee = m_err;
        end else begin
            em = v.e_mask; et = v.e_total; ee = v.e_err;
        end
        chk({tag, "_mask"}, pending_mask, em);
        chk({tag, "_total"}, 32'(inflight_total), 32'(et));
        chk({tag, "_err"}, 32'(err_underflow), 32'(ee));
        @(negedge clk);
    endtask

    vec_t tbl[14];
    vec_t v;

    initial begin
        //          req wr rd r1r rs1 r2r rs2 wbw wbno  stall ack mask      total err
        tbl[0]  = '{1, 1, 5,  0, 0,  0, 0,  0, 0,    0, 1, 32'h020, 1, 0};
        tbl[1]  = '{1, 0, 0,  1, 5,  0, 0,  0, 0,    1, 0, 32'h020, 1, 0};
        tbl[2]  = '{1, 0, 0,  0, 0,  1, 5,  1, 5,    0, 1, 32'h000, 0, 0};
        tbl[3]  = '{1, 1, 7,  0, 0,  0, 0,  0, 0,    0, 1, 32'h080, 1, 0};
        tbl[4]  = '{1, 1, 7,  0, 0,  0, 0,  0, 0,    0, 1, 32'h080, 2, 0};
        tbl[5]  = '{1, 1, 7,  0, 0,  0, 0,  0, 0,    0, 1, 32'h080, 3, 0};
        tbl[6]  = '{1, 1, 7,  0, 0,  0, 0,  0, 0,    1, 0, 32'h080, 3, 0};
        tbl[7]  = '{1, 1, 9,  0, 0,  0, 0,  0, 0,    0, 1, 32'h280, 4, 0};
        tbl[8]  = '{1, 1, 9,  0, 0,  0, 0,  1, 9,    0, 1, 32'h280, 4, 0};
        tbl[9]  = '{1, 1, 0,  1, 0,  1, 0,  1, 0,    0, 1, 32'h280, 4, 0};
        tbl[10] = '{0, 0, 0,  1, 7,  0, 0,  0, 0,    0, 0, 32'h280, 4, 0};
        tbl[11] = '{1, 0, 0,  1, 7,  0, 0,  1, 7,    1, 0, 32'h280, 3, 0};
        tbl[12] = '{0, 0, 0,  0, 0,  0, 0,  1, 12,   0, 0, 32'h280, 3, 1};
        tbl[13] = '{0, 0, 0,  0, 0,  0, 0,  0, 0,    0, 0, 32'h280, 3, 1};

        reset = 1;
        drive_idle();
        @(negedge clk);
        do_reset();

        for (int i = 0; i < 14; i++) apply($sformatf("vec%0d", i), tbl[i], 0);

        // Reset clears sticky error and all counters mid-operation.
        do_reset();

        // x0 traffic after reset: never stalls, nothing becomes pending.
        v = '{1, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1, 32'h0, 0, 0};
        apply("x0", v, 0);

        // Back-to-back independent issues take no penalty; dependent one stalls.
        v = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h002, 1, 0};
        apply("b2b_a", v, 0);
        v = '{1, 1, 2, 1, 3, 1, 4, 0, 0, 0, 1, 32'h006, 2, 0};
        apply("b2b_b", v, 0);
        v = '{1, 1, 3, 0, 0, 1, 2, 0, 0, 1, 0, 32'h006, 2, 0};
        apply("b2b_dep", v, 0);

        // Randomized phase against the counting model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                v.req  = ($urandom_range(0, 3) != 0);
                v.wr   = ($urandom_range(0, 2) != 0);
                v.rd   = $urandom_range(0, 7);
                v.r1r  = $urandom_range(0, 1);
                v.rs1  = $urandom_range(0, 7);
                v.r2r  = $urandom_range(0, 1);
                v.rs2  = $urandom_range(0, 7);
                v.wbno = $urandom_range(0, 7);
                v.wbw  = ($urandom_range(0, 1) == 1);
                if (m_cnt[v.wbno] == 0 && $urandom_range(0, 39) != 0) v.wbw = 0;
                apply("rnd", v, 1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
